// File: rtl/data_memory_sized_if.sv
// data_memory_sized_if: load/store request bus between the MEM stage and the data memory
interface data_memory_sized_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;
    logic        unsigned_load;
    logic [31:0] read_data;
    logic        stall;
    logic        misaligned;

    modport master (
        output address, write_data, mem_write, mem_read, size, unsigned_load,
        input  read_data, stall, misaligned
    );

    modport slave (
        input  address, write_data, mem_write, mem_read, size, unsigned_load,
        output read_data, stall, misaligned
    );
endinterface

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte/half/word data memory with configurable read latency and stall
module data_memory_sized #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 2
) (
    input logic clk,
    input logic rst,
    data_memory_sized_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state;
    logic [2:0]            cnt;
    logic [ADDR_BITS-1:0]  l_idx;
    logic [1:0]            l_off;
    logic [1:0]            l_size;
    logic                  l_uns;
    logic [31:0]           rd_reg;
    logic [31:0]           mem [DEPTH] = '{default: '0};

    logic [ADDR_BITS-1:0]  idx;
    logic [1:0]            off;
    logic                  mis;
    logic                  we;
    logic                  accept;
    logic [3:0]            be;
    logic [31:0]           wdata;

    // Pick the addressed byte/half out of a word and sign- or zero-extend it.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] o,
                                           input logic [1:0] sz, input logic uns);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> {o, 3'b000};
        h = w >> {o[1], 4'b0000};
        return sz == 2'b00 ? {{24{~uns & b[7]}}, b[7:0]} :
               sz == 2'b01 ? {{16{~uns & h[15]}}, h[15:0]} : w;
    endfunction

    // Decode the request: alignment, byte enables, lane-replicated store data.
    always_comb begin
        idx    = bus.address[ADDR_BITS+1:2];
        off    = bus.address[1:0];
        mis    = (bus.mem_write | bus.mem_read) &&
                 (bus.size == 2'b01 ? off[0] : bus.size[1] ? off != 2'b00 : 1'b0);
        we     = bus.mem_write && !mis && state != WAIT && !rst;
        accept = state == IDLE && bus.mem_read && !bus.mem_write && !mis;
        be     = bus.size == 2'b00 ? 4'b0001 << off :
                 bus.size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata  = bus.size == 2'b00 ? {4{bus.write_data[7:0]}} :
                 bus.size == 2'b01 ? {2{bus.write_data[15:0]}} : bus.write_data;
    end

    // Outputs: stall covers the accept cycle plus WAIT; data only in a completing cycle.
    always_comb begin
        bus.misaligned = mis;
        bus.stall      = state == WAIT || (accept && READ_LATENCY > 0);
        bus.read_data  = state == DONE ? rd_reg :
                         (READ_LATENCY == 0 && accept) ? extend(mem[idx], off, bus.size, bus.unsigned_load) :
                         32'h0;
    end

    // Single-cycle store of the enabled byte lanes; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    // Load sequencer: the accept cycle is the first stall cycle, so WAIT lasts
    // READ_LATENCY-1 cycles and the counter holds the WAIT cycles still to go.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            l_idx  <= '0;
            l_off  <= '0;
            l_size <= '0;
            l_uns  <= 1'b0;
            rd_reg <= '0;
        end else begin
            case (state)
                IDLE: if (accept && READ_LATENCY > 0) begin
                    l_idx  <= idx;
                    l_off  <= off;
                    l_size <= bus.size;
                    l_uns  <= bus.unsigned_load;
                    if (READ_LATENCY == 1) begin
                        cnt    <= '0;
                        rd_reg <= extend(mem[idx], off, bus.size, bus.unsigned_load);
                        state  <= DONE;
                    end else begin
                        cnt   <= 3'(READ_LATENCY - 2);
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == 3'd0) begin
                    rd_reg <= extend(mem[l_idx], l_off, l_size, l_uns);
                    state  <= DONE;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                DONE: begin
                    rd_reg <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
